// File: rtl/store_buffer.sv
// Posted-store FIFO between the M-stage store path and the data-memory write port,
// with byte-granular load forwarding. Optional store coalescing: STORE_BUF_COALESCE_EN.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            st_valid,
  input  logic [31:0]     st_addr,
  input  logic [31:0]     st_wdata,
  input  logic [3:0]      st_be,
  input  logic [31:0]     st_pc,
  output logic            st_ready,
  input  logic            ld_valid,
  input  logic [31:0]     ld_addr,
  output logic            ld_hit,
  output logic [3:0]      ld_hit_be,
  output logic [31:0]     ld_fwd_data,
  input  logic            dm_busy,
  output logic            dm_we,
  output logic [31:0]     dm_addr,
  output logic [31:0]     dm_wdata,
  output logic [3:0]      dm_be,
  output logic [31:0]     dm_pc,
  output logic            empty,
  output logic [PTRW:0]   count
);

  localparam logic [PTRW:0] FULL_CNT = DEPTH[PTRW:0];

  logic [29:0]     word_q  [DEPTH];
  logic [29:0]     word_d  [DEPTH];
  logic [31:0]     data_q  [DEPTH];
  logic [31:0]     data_d  [DEPTH];
  logic [3:0]      be_q    [DEPTH];
  logic [3:0]      be_d    [DEPTH];
  logic [31:0]     pc_q    [DEPTH];
  logic [31:0]     pc_d    [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [PTRW-1:0] head_q, head_d;
  logic [PTRW-1:0] tail_q, tail_d;
  logic [PTRW:0]   count_q, count_d;

  logic [PTRW-1:0] youngest;
  logic            merge_possible;
  logic            push;
  logic            alloc;
  logic            do_merge;

  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign dm_we    = !empty && !dm_busy;
  assign dm_addr  = {word_q[head_q], 2'b00};
  assign dm_wdata = data_q[head_q];
  assign dm_be    = be_q[head_q];
  assign dm_pc    = pc_q[head_q];
  assign youngest = tail_q - 1'b1;

`ifdef STORE_BUF_COALESCE_EN
  // Merging into the head while it drains would lose the new bytes, so allocate instead.
  assign merge_possible = !empty && (word_q[youngest] == st_addr[31:2])
                          && !((youngest == head_q) && dm_we);
`else
  assign merge_possible = 1'b0;
`endif

  // A same-cycle pop deliberately does not open a slot for this cycle's push.
  assign st_ready = (count_q != FULL_CNT) || merge_possible;
  assign push     = st_valid && st_ready;
  assign do_merge = push && merge_possible;
  assign alloc    = push && !merge_possible;

  always_comb begin
    word_d  = word_q;
    data_d  = data_q;
    be_d    = be_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (dm_we) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    if (alloc) begin
      word_d[tail_q]  = st_addr[31:2];
      data_d[tail_q]  = st_wdata;
      be_d[tail_q]    = st_be;
      pc_d[tail_q]    = st_pc;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end

    if (do_merge) begin
      for (int l = 0; l < 4; l++) begin
        if (st_be[l]) begin
          data_d[youngest][8*l +: 8] = st_wdata[8*l +: 8];
        end
      end
      be_d[youngest] = be_q[youngest] | st_be;
      pc_d[youngest] = st_pc;
    end

    case ({alloc, dm_we})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= word_d[i];
        data_q[i] <= data_d[i];
        be_q[i]   <= be_d[i];
        pc_q[i]   <= pc_d[i];
      end
    end
  end

  // Per lane, walk from oldest (distance DEPTH from tail) to youngest so the youngest match wins.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic            lane_hit;
      logic [7:0]      lane_byte;
      logic [PTRW-1:0] idx;

      always_comb begin
        lane_hit  = 1'b0;
        lane_byte = 8'h00;
        idx       = '0;
        for (int k = DEPTH; k >= 1; k--) begin
          idx = tail_q - PTRW'(k);
          if (valid_q[idx] && (word_q[idx] == ld_addr[31:2]) && be_q[idx][gi]) begin
            lane_hit  = 1'b1;
            lane_byte = data_q[idx][8*gi +: 8];
          end
        end
      end

      assign ld_hit_be[gi]          = ld_valid && lane_hit;
      assign ld_fwd_data[8*gi +: 8] = (ld_valid && lane_hit) ? lane_byte : 8'h00;
    end
  endgenerate

  assign ld_hit = |ld_hit_be;

endmodule

// File: tb/tb_store_buffer.sv
// Randomized scoreboard bench for store_buffer: a queue-based reference model predicts
// status and forwarding each cycle; a separate monitor checks every DM write against it.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int PTRW  = 2;

  logic            clk;
  logic            reset;
  logic            st_valid;
  logic [31:0]     st_addr;
  logic [31:0]     st_wdata;
  logic [3:0]      st_be;
  logic [31:0]     st_pc;
  logic            st_ready;
  logic            ld_valid;
  logic [31:0]     ld_addr;
  logic            ld_hit;
  logic [3:0]      ld_hit_be;
  logic [31:0]     ld_fwd_data;
  logic            dm_busy;
  logic            dm_we;
  logic [31:0]     dm_addr;
  logic [31:0]     dm_wdata;
  logic [3:0]      dm_be;
  logic [31:0]     dm_pc;
  logic            empty;
  logic [PTRW:0]   count;

  store_buffer #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata), .st_be(st_be),
    .st_pc(st_pc), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_hit_be(ld_hit_be),
    .ld_fwd_data(ld_fwd_data),
    .dm_busy(dm_busy), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_pc(dm_pc), .empty(empty), .count(count)
  );

  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } ent_t;

  ent_t sb_q[$];   // queued stores, oldest at front
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict and compare combinational outputs, apply push to model.
  task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [3:0] sb, input logic [31:0] spc,
                       input logic lv, input logic [31:0] la, input logic busy);
    int n;
    logic e_we, merge, e_ready;
    logic [3:0] e_hbe;
    logic [31:0] e_fd;
    ent_t e;
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_wdata = sd; st_be = sb; st_pc = spc;
    ld_valid = lv; ld_addr = la; dm_busy = busy;
    #1;
    n     = sb_q.size();
    e_we  = (n != 0) && !busy;
    merge = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    if (n != 0 && sb_q[n-1].word == sa[31:2] && !(n == 1 && e_we)) merge = 1'b1;
`endif
    e_ready = (n != DEPTH) || merge;
    e_hbe = 4'h0;
    e_fd  = 32'h0;
    if (lv) begin
      for (int l = 0; l < 4; l++) begin
        for (int j = n - 1; j >= 0; j--) begin
          if (sb_q[j].word == la[31:2] && sb_q[j].be[l]) begin
            e_hbe[l] = 1'b1;
            e_fd[8*l +: 8] = sb_q[j].data[8*l +: 8];
            break;
          end
        end
      end
    end
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("st_ready", 32'(st_ready), 32'(e_ready));
    chk("dm_we", 32'(dm_we), 32'(e_we));
    chk("ld_hit", 32'(ld_hit), 32'(e_hbe != 4'h0));
    chk("ld_hit_be", 32'(ld_hit_be), 32'(e_hbe));
    chk("ld_fwd_data", ld_fwd_data, e_fd);
    $display("cyc t=%0t st=%0b a=%08h be=%h rdy=%0b ld=%0b la=%08h hbe=%h fwd=%08h busy=%0b we=%0b cnt=%0d",
             $time, sv, sa, sb, st_ready, lv, la, ld_hit_be, ld_fwd_data, busy, dm_we, count);
    if (sv && e_ready) begin
      if (merge) begin
        e = sb_q[n-1];
        for (int l = 0; l < 4; l++) if (sb[l]) e.data[8*l +: 8] = sd[8*l +: 8];
        e.be = e.be | sb;
        e.pc = spc;
        sb_q[n-1] = e;
      end else begin
        e.word = sa[31:2]; e.data = sd; e.be = sb; e.pc = spc;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic busy);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, busy);
  endtask

  // Asynchronous reset asserted between edges; state must clear immediately.
  task automatic rst_pulse();
    @(negedge clk);
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h0; dm_busy = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_ld_hit", 32'(ld_hit), 32'd0);
    chk("rst_ld_fwd", ld_fwd_data, 32'd0);
    sb_q.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    ld_valid = 1'b0;
  endtask

  // Monitor: every DM write must match the oldest queued store of the model.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (dm_we === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("dm_unexpected_write", 32'(dm_we), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("dm_addr", dm_addr, {e.word, 2'b00});
          chk("dm_wdata", dm_wdata, e.data);
          chk("dm_be", 32'(dm_be), 32'(e.be));
          chk("dm_pc", dm_pc, e.pc);
          $display("dmw t=%0t addr=%08h data=%08h be=%h pc=%08h", $time, dm_addr, dm_wdata, dm_be, dm_pc);
        end
      end
    end
  end

  initial begin
    logic [31:0] ra, rl;
    reset = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_be = '0; st_pc = '0;
    ld_valid = 1'b0; ld_addr = '0; dm_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // Async reset from an idle buffer.
    rst_pulse();

    // Single store drains on the following cycle.
    cycle(1'b1, 32'h10, 32'h11223344, 4'hF, 32'h100, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    chk("t2_dm_addr", dm_addr, 32'h10);
    chk("t2_dm_wdata", dm_wdata, 32'h11223344);
    idle(1'b0);
    chk("t2_empty", 32'(empty), 32'd1);

    // Fill while blocked, fifth store held until the first pop.
    rst_pulse();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'(i * 4), $urandom, 4'hF, 32'(i), 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h10, 32'h55555555, 4'hF, 32'h4, 1'b0, 32'h0, 1'b1);
    chk("t3_full_ready", 32'(st_ready), 32'd0);
    chk("t3_full_count", 32'(count), 32'd4);
    cycle(1'b1, 32'h10, 32'h55555555, 4'hF, 32'h4, 1'b0, 32'h0, 1'b0);
    chk("t3_pop_no_space", 32'(st_ready), 32'd0);
    cycle(1'b1, 32'h10, 32'h55555555, 4'hF, 32'h4, 1'b0, 32'h0, 1'b0);
    chk("t3_accept_after_pop", 32'(st_ready), 32'd1);
    repeat (5) idle(1'b0);

    // Youngest-byte forwarding, then the same with the tail wrapped.
    for (int pass = 0; pass < 2; pass++) begin
      rst_pulse();
      if (pass == 1) begin
        for (int i = 0; i < 3; i++)
          cycle(1'b1, 32'h40 + 32'(i * 4), $urandom, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) idle(1'b0);
      end
      cycle(1'b1, 32'h20, 32'h0000AAAA, 4'h3, 32'h200, 1'b0, 32'h0, 1'b1);
      cycle(1'b1, 32'h20, 32'h0000BB00, 4'h2, 32'h204, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h22, 1'b1);
      chk("t4_ld_hit", 32'(ld_hit), 32'd1);
      chk("t4_ld_hit_be", 32'(ld_hit_be), 32'h3);
      chk("t4_ld_fwd", ld_fwd_data, 32'h0000BBAA);
      repeat (3) idle(1'b0);
    end

    // Same-word stores: coalesced into one entry or kept separate.
    rst_pulse();
    cycle(1'b1, 32'h30, 32'h000000AA, 4'h1, 32'h300, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h30, 32'h00CC0000, 4'h4, 32'h304, 1'b0, 32'h0, 1'b1);
    idle(1'b1);
`ifdef STORE_BUF_COALESCE_EN
    chk("t6_count", 32'(count), 32'd1);
`else
    chk("t6_count", 32'(count), 32'd2);
`endif
    repeat (3) idle(1'b0);

    // Randomized traffic on a small address window to force overlaps.
    rst_pulse();
    for (int c = 0; c < 3000; c++) begin
      ra = ($urandom_range(0, 5) << 2) | ($urandom & 32'h3);
      rl = ($urandom_range(0, 5) << 2) | ($urandom & 32'h3);
      cycle(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), rl, $urandom_range(0, 2) == 0);
      if (c == 1500) rst_pulse();
    end
    repeat (8) idle(1'b0);
    chk("final_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
